// File: rtl/car_pkg.sv
// Shared encodings for the car drive controller: start-state codes, mode codes and FSM states.
// Pure definitions, no timing or flow control.
package car_pkg;

    localparam logic [1:0] ST_OFF         = 2'b00;
    localparam logic [1:0] ST_NOT_STARTED = 2'b01;
    localparam logic [1:0] ST_STARTED     = 2'b10;
    localparam logic [1:0] ST_MOVING      = 2'b11;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_MAN  = 2'b01;
    localparam logic [1:0] MODE_SEMI = 2'b10;
    localparam logic [1:0] MODE_AUTO = 2'b11;

    typedef enum logic [2:0] {
        S_OFF,
        S_IDLE,
        S_MAN,
        S_SEMI,
        S_AUTO
    } fsm_state_t;

    function automatic logic [1:0] mode_of(input fsm_state_t s);
        case (s)
            S_MAN:   return MODE_MAN;
            S_SEMI:  return MODE_SEMI;
            S_AUTO:  return MODE_AUTO;
            default: return MODE_NONE;
        endcase
    endfunction

    // Opposing requests cancel each other: {a_out, b_out}.
    function automatic logic [1:0] pair_mask(input logic a, input logic b);
        return {a & ~b, b & ~a};
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Counts consecutive cycles of `level`; emits a one-cycle registered `done` on the CYCLES-th high sample.
// Any low sample or `clear` restarts from zero; the count saturates and never wraps.
module hold_counter #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic level,
    output logic done
);

    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);
    localparam logic [W-1:0] SAT  = W'(CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear || !level) begin
                count <= '0;
            end else if (count == LAST) begin
                count <= '0;
                done  <= 1'b1;
            end else if (count != SAT) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/car_mode_ctrl.sv
// Power sequencing, start-state register and arbitration of one motion output set between three drivers.
// All outputs registered, one cycle from inputs; a mode switch waits until the granted driver can let go.
module car_mode_ctrl
    import car_pkg::*;
#(
    parameter int PWR_HOLD_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on_btn,
    input  logic       power_off_btn,
    input  logic [1:0] mode_sel,
    input  logic [1:0] man_state_next,
    input  logic       man_break,
    input  logic       man_fwd,
    input  logic       man_bwd,
    input  logic       man_left,
    input  logic       man_right,
    input  logic       semi_fwd,
    input  logic       semi_bwd,
    input  logic       semi_left,
    input  logic       semi_right,
    input  logic       semi_busy,
    input  logic       auto_fwd,
    input  logic       auto_bwd,
    input  logic       auto_left,
    input  logic       auto_right,
    input  logic       auto_busy,
    output logic [1:0] state_cur,
    output logic       man_enable,
    output logic       semi_enable,
    output logic       auto_enable,
    output logic       power_led,
    output logic       move_forward,
    output logic       move_backward,
    output logic       turn_left,
    output logic       turn_right,
    output logic [1:0] mode_active
);

    fsm_state_t state, state_nx;
    logic [1:0] state_cur_nx;
    logic [3:0] req;
    logic [3:0] move_nx;
    logic       pwr_done;
    logic       rearmed;

    // A button still held when power drops must be released before it can count again.
    hold_counter #(.CYCLES(PWR_HOLD_CYCLES)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .clear (state != S_OFF),
        .level (power_on_btn & rearmed),
        .done  (pwr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rearmed <= 1'b1;
        end else if (!power_on_btn) begin
            rearmed <= 1'b1;
        end else if (state != S_OFF && state_nx == S_OFF) begin
            rearmed <= 1'b0;
        end
    end

    always_comb begin
        state_nx     = state;
        state_cur_nx = state_cur;
        case (state)
            S_OFF: begin
                if (pwr_done) begin
                    state_nx     = S_IDLE;
                    state_cur_nx = ST_NOT_STARTED;
                end
            end
            S_IDLE: begin
                case (mode_sel)
                    MODE_MAN:  state_nx = S_MAN;
                    MODE_SEMI: state_nx = S_SEMI;
                    MODE_AUTO: state_nx = S_AUTO;
                    default:   state_nx = S_IDLE;
                endcase
                if (mode_sel != MODE_NONE) state_cur_nx = ST_NOT_STARTED;
            end
            S_MAN: begin
                state_cur_nx = man_state_next;
                if (man_break) begin
                    state_nx = S_OFF;
                end else if (mode_sel != MODE_MAN && state_cur == ST_NOT_STARTED) begin
                    state_nx     = S_IDLE;
                    state_cur_nx = state_cur;
                end
            end
            S_SEMI: if (mode_sel != MODE_SEMI && !semi_busy) state_nx = S_IDLE;
            S_AUTO: if (mode_sel != MODE_AUTO && !auto_busy) state_nx = S_IDLE;
            default: state_nx = S_OFF;
        endcase
        if (state != S_OFF && power_off_btn) state_nx = S_OFF;
        if (state_nx == S_OFF) state_cur_nx = ST_OFF;
    end

    always_comb begin
        req = 4'b0000;
        case (state_nx)
            S_MAN:   req = {man_fwd, man_bwd, man_left, man_right};
            S_SEMI:  req = {semi_fwd, semi_bwd, semi_left, semi_right};
            S_AUTO:  req = {auto_fwd, auto_bwd, auto_left, auto_right};
            default: req = 4'b0000;
        endcase
        move_nx = {pair_mask(req[3], req[2]), pair_mask(req[1], req[0])};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_OFF;
            state_cur     <= ST_OFF;
            man_enable    <= 1'b0;
            semi_enable   <= 1'b0;
            auto_enable   <= 1'b0;
            power_led     <= 1'b0;
            move_forward  <= 1'b0;
            move_backward <= 1'b0;
            turn_left     <= 1'b0;
            turn_right    <= 1'b0;
            mode_active   <= MODE_NONE;
        end else begin
            state         <= state_nx;
            state_cur     <= state_cur_nx;
            man_enable    <= (state_nx == S_MAN);
            semi_enable   <= (state_nx == S_SEMI);
            auto_enable   <= (state_nx == S_AUTO);
            power_led     <= (state_nx != S_OFF);
            {move_forward, move_backward, turn_left, turn_right} <= move_nx;
            mode_active   <= mode_of(state_nx);
        end
    end

endmodule

// File: tb/tb_car_mode_ctrl.sv
// Directed bench for car_mode_ctrl with a 4-cycle power-on hold.
module tb_car_mode_ctrl;
    import car_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       power_on_btn, power_off_btn;
    logic [1:0] mode_sel, man_state_next;
    logic       man_break, man_fwd, man_bwd, man_left, man_right;
    logic       semi_fwd, semi_bwd, semi_left, semi_right, semi_busy;
    logic       auto_fwd, auto_bwd, auto_left, auto_right, auto_busy;
    logic [1:0] state_cur, mode_active;
    logic       man_enable, semi_enable, auto_enable, power_led;
    logic       move_forward, move_backward, turn_left, turn_right;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    car_mode_ctrl #(.PWR_HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .power_on_btn(power_on_btn), .power_off_btn(power_off_btn),
        .mode_sel(mode_sel), .man_state_next(man_state_next),
        .man_break(man_break), .man_fwd(man_fwd), .man_bwd(man_bwd),
        .man_left(man_left), .man_right(man_right),
        .semi_fwd(semi_fwd), .semi_bwd(semi_bwd), .semi_left(semi_left),
        .semi_right(semi_right), .semi_busy(semi_busy),
        .auto_fwd(auto_fwd), .auto_bwd(auto_bwd), .auto_left(auto_left),
        .auto_right(auto_right), .auto_busy(auto_busy),
        .state_cur(state_cur), .man_enable(man_enable), .semi_enable(semi_enable),
        .auto_enable(auto_enable), .power_led(power_led),
        .move_forward(move_forward), .move_backward(move_backward),
        .turn_left(turn_left), .turn_right(turn_right), .mode_active(mode_active)
    );

    always #5 clk = ~clk;

    // {state_cur, man_en, semi_en, auto_en, led, fwd, bwd, left, right, mode_active}
    function automatic logic [15:0] outs();
        return {3'b000, state_cur, man_enable, semi_enable, auto_enable, power_led,
                move_forward, move_backward, turn_left, turn_right, mode_active};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic power_up();
        power_on_btn = 1'b1;
        repeat (5) tick();
        power_on_btn = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        power_on_btn = 0; power_off_btn = 0; mode_sel = MODE_NONE; man_state_next = ST_OFF;
        man_break = 0; man_fwd = 0; man_bwd = 0; man_left = 0; man_right = 0;
        semi_fwd = 0; semi_bwd = 0; semi_left = 0; semi_right = 0; semi_busy = 0;
        auto_fwd = 0; auto_bwd = 0; auto_left = 0; auto_right = 0; auto_busy = 0;
        #12;
        chk("reset_outs", outs(), 16'h0000);
        rst = 1'b0;
        tick();

        // Too short a hold.
        power_on_btn = 1'b1;
        repeat (3) tick();
        power_on_btn = 1'b0;
        repeat (2) tick();
        chk("short_hold_led", {15'd0, power_led}, 16'd0);

        // Full hold: led rises on the 4th cycle after the first high sample.
        power_on_btn = 1'b1;
        repeat (4) tick();
        chk("hold4_led_not_yet", {15'd0, power_led}, 16'd0);
        tick();
        chk("power_on_led", {15'd0, power_led}, 16'd1);
        chk("power_on_state", {14'd0, state_cur}, {14'd0, ST_NOT_STARTED});
        chk("power_on_mode", {14'd0, mode_active}, {14'd0, MODE_NONE});
        power_on_btn = 1'b0;

        // Manual drive.
        mode_sel = MODE_MAN; man_state_next = ST_MOVING; man_fwd = 1'b1;
        tick();
        // state_cur 01, man_en, led, fwd, mode 01
        chk("man_entry", outs(), {3'b000, 2'b01, 4'b1001, 4'b1000, 2'b01});
        tick();
        chk("man_moving_state", {14'd0, state_cur}, {14'd0, ST_MOVING});
        man_break = 1'b1;
        tick();
        chk("man_break_off", outs(), 16'h0000);
        man_break = 1'b0; man_fwd = 1'b0; mode_sel = MODE_NONE;

        // Mode change deferred until manual state returns to not-started.
        power_up();
        chk("repower_led", {15'd0, power_led}, 16'd1);
        mode_sel = MODE_MAN; man_state_next = ST_MOVING;
        repeat (2) tick();
        mode_sel = MODE_SEMI;
        tick();
        chk("man_hold_grant", {14'd0, mode_active}, {14'd0, MODE_MAN});
        man_state_next = ST_NOT_STARTED;
        tick();
        chk("man_still_granted", {13'd0, mode_active, man_enable}, {13'd0, MODE_MAN, 1'b1});
        tick();
        chk("idle_gap", {12'd0, mode_active, man_enable, semi_enable}, 16'd0);
        tick();
        chk("semi_granted", {13'd0, mode_active, semi_enable}, {13'd0, MODE_SEMI, 1'b1});

        // Power-off beats a busy semi-auto driver.
        semi_busy = 1'b1; semi_left = 1'b1;
        tick();
        chk("semi_left", {15'd0, turn_left}, 16'd1);
        power_off_btn = 1'b1;
        tick();
        chk("semi_power_off", outs(), 16'h0000);
        power_off_btn = 1'b0; semi_busy = 1'b0; semi_left = 1'b0; mode_sel = MODE_NONE;

        // Auto: busy holds the grant, opposing requests cancel.
        power_up();
        mode_sel = MODE_AUTO;
        tick();
        chk("auto_granted", {13'd0, mode_active, auto_enable}, {13'd0, MODE_AUTO, 1'b1});
        auto_busy = 1'b1; mode_sel = MODE_NONE;
        tick();
        chk("auto_busy_hold", {14'd0, mode_active}, {14'd0, MODE_AUTO});
        auto_fwd = 1'b1; auto_bwd = 1'b1; auto_right = 1'b1;
        tick();
        chk("auto_cancel", {12'd0, move_forward, move_backward, turn_left, turn_right}, 16'b0001);
        auto_busy = 1'b0;
        tick();
        chk("auto_release_idle", {10'd0, mode_active, auto_enable, move_forward, move_backward,
            turn_left, turn_right, power_led}, 16'b1);
        auto_fwd = 1'b0; auto_bwd = 1'b0; auto_right = 1'b0;

        // Power-on button held through a power-off must be released first.
        power_on_btn = 1'b1; power_off_btn = 1'b1;
        tick();
        power_off_btn = 1'b0;
        repeat (6) tick();
        chk("no_rearm_led", {15'd0, power_led}, 16'd0);
        power_on_btn = 1'b0;
        tick();
        power_up();
        chk("rearm_led", {15'd0, power_led}, 16'd1);

        // Asynchronous reset while moving.
        mode_sel = MODE_MAN; man_state_next = ST_MOVING; man_fwd = 1'b1;
        repeat (2) tick();
        chk("pre_reset_moving", {14'd0, state_cur}, {14'd0, ST_MOVING});
        rst = 1'b1;
        #2;
        chk("async_reset_outs", outs(), 16'h0000);
        rst = 1'b0;
        mode_sel = MODE_NONE; man_fwd = 1'b0;

        // Reset mid-hold restarts the count.
        power_on_btn = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        repeat (3) tick();
        chk("hold_restart_led", {15'd0, power_led}, 16'd0);
        repeat (2) tick();
        chk("hold_restart_on", {15'd0, power_led}, 16'd1);
        power_on_btn = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/car_mode_ctrl.md
# car_mode_ctrl

Top-level drive controller for the car simulation. Owns the power/start state register that the manual-driving block only computes combinationally, and sequences power-on/power-off. Arbitrates the single motion output set between the manual, semi-auto and auto drivers according to the mode switches. Sits between the board-input debouncers and the chassis/display outputs; the manual block's `state_cur` input is fed from here.

## Interface
- `PWR_HOLD_CYCLES`, default 100_000_000: consecutive cycles `power_on_btn` must be held to power on (1 s at 100 MHz).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `power_on_btn`  in  1  debounced power-on button, level.
- `power_off_btn`  in  1  debounced power-off button, level.
- `mode_sel`  in  2  requested mode: 00 none, 01 manual, 10 semi-auto, 11 auto.
- `man_state_next`  in  2  next start-state from manual block.
- `man_break`  in  1  manual block stall/power-off request.
- `man_fwd`, `man_bwd`, `man_left`, `man_right`  in  1 each  manual motion requests.
- `semi_fwd`, `semi_bwd`, `semi_left`, `semi_right`, `semi_busy`  in  1 each  semi-auto requests; busy = mid-manoeuvre.
- `auto_fwd`, `auto_bwd`, `auto_left`, `auto_right`, `auto_busy`  in  1 each  auto requests.
- `state_cur`  out  2  start-state register: 00 off, 01 not started, 10 started, 11 moving.
- `man_enable`, `semi_enable`, `auto_enable`  out  1 each  one-hot driver enables.
- `power_led`  out  1  high when powered.
- `move_forward`, `move_backward`, `turn_left`, `turn_right`  out  1 each  arbitrated motion.
- `mode_active`  out  2  currently granted mode, same encoding as `mode_sel`.

## Operation
- FSM states: OFF, IDLE, MAN, SEMI, AUTO. Reset -> OFF.
- OFF: hold counter counts while `power_on_btn`=1, clears when 0. When count reaches `PWR_HOLD_CYCLES`-1 with button still high -> IDLE, `state_cur`<=01, counter cleared. Power-on needs button release and new hold after any power-off.
- IDLE: `mode_sel`=01/10/11 -> MAN/SEMI/AUTO next cycle; `state_cur`<=01 on every mode entry.
- MAN: `state_cur`<=`man_state_next` each cycle. `man_break`=1 -> OFF.
- Leaving a mode (mode_sel differs from granted mode): MAN only when `state_cur`=01; SEMI only when `semi_busy`=0; AUTO only when `auto_busy`=0. Otherwise grant holds, new request ignored until condition met. Exit goes to IDLE for one cycle, then to requested mode if non-zero.
- `power_off_btn`=1 in any powered state -> OFF; highest priority, beats `man_break`, mode change and busy.
- Motion mux: granted driver's four requests; OFF/IDLE -> all 0. fwd&bwd both requested -> both 0; left&right both -> both 0.
- Enables one-hot per granted mode, all 0 in OFF/IDLE. `mode_active`=00 in OFF/IDLE.

## Timing
- Reset values: `state_cur`=00, all enables 0, `power_led`=0, all motion 0, `mode_active`=00, counter 0.
- All outputs registered; inputs -> outputs latency 1 cycle.
- Power-on: `power_led` rises exactly `PWR_HOLD_CYCLES` cycles after first high sample of button.
- In OFF, `state_cur`=00 and motion 0 on the cycle after entry.
- Counter width `$clog2(PWR_HOLD_CYCLES+1)`, saturates, never wraps.
- Reset mid-operation: immediate return to reset values regardless of state.

## Structure
- Shared package `car_pkg`: start-state codes (ST_OFF=00, ST_NOT_STARTED=01, ST_STARTED=10, ST_MOVING=11), mode codes (MODE_NONE..MODE_AUTO), FSM state enum.
- One sub-module `hold_counter` (param cycles; in: clk, rst, clear, level; out: done pulse) for the power-on hold.
- Remainder (FSM, state register, motion mux) in `car_mode_ctrl`.

## Test plan
- `PWR_HOLD_CYCLES`=4: hold `power_on_btn` 3 cycles, release -> stays OFF; hold 4 cycles -> `power_led`=1, `state_cur`=01 next cycle.
- Powered, `mode_sel`=01, `man_state_next`=11, `man_fwd`=1 -> `mode_active`=01, `state_cur`=11, `move_forward`=1; `man_break`=1 -> `state_cur`=00, motion 0.
- MAN with `state_cur`=11, `mode_sel`->10 -> grant stays 01; `man_state_next`=01 -> IDLE one cycle, then `mode_active`=10, `semi_enable`=1.
- AUTO, `auto_busy`=1, `mode_sel`=00 -> stays AUTO; `auto_fwd`=`auto_bwd`=1 -> both outputs 0; `auto_busy`=0 -> IDLE.
- SEMI, `semi_busy`=1, `power_off_btn`=1 -> OFF next cycle, all outputs at reset values.
- Assert `rst` while in MAN moving -> all outputs to reset values asynchronously; power-on hold restarts from 0.
